serial_subtractor: RTL

Bit-serial N-bit subtractor computing `a - b - bin` one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow. It is the inverse-direction companion to the team's combinational full-adder cell and is used where area matters more than latency. A start/busy/done handshake lets a controller or testbench launch one operation at a time.

---
 rtl/serial_subtractor.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (a - b - bin), LSB first, one full-subtractor cell per clock.
// Optional feature: define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf_o.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             bin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] diff_o,
    output logic             bout_o
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf_o
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic             x_bit, y_bit, d_bit, bo_bit;

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb_q, a_msb_d;
    logic b_msb_q, b_msb_d;
    logic ovf_q, ovf_d;
`endif

    // Single full-subtractor cell shared across all bit positions.
    assign x_bit  = a_q[0];
    assign y_bit  = b_q[0];
    assign d_bit  = x_bit ^ y_bit ^ br_q;
    assign bo_bit = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & br_q);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d = S_RUN;
                    a_d     = a_i;
                    b_d     = b_i;
                    br_d    = bin_i;
                    cnt_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
                    a_msb_d = a_i[WIDTH-1];
                    b_msb_d = b_i[WIDTH-1];
`endif
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = {d_bit, res_q[WIDTH-1:1]};
                br_d  = bo_bit;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    // Final bit: publish the completed result in the same edge.
                    state_d = S_DONE;
                    diff_d  = {d_bit, res_q[WIDTH-1:1]};
                    bout_d  = bo_bit;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d   = (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ovf_o = ovf_q;
`endif

    assign busy_o = (state_q == S_RUN);
    assign done_o = (state_q == S_DONE);
    assign diff_o = diff_q;
    assign bout_o = bout_q;

endmodule
